alarme_sirene: RTL and testbench



---
 rtl/alarme_pkg.sv | 19 +
 rtl/alarme_temporizador.sv | 37 +++
 rtl/alarme_sirene.sv | 106 ++++++++++
 tb/tb_alarme_sirene.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarme_pkg.sv
// rtl/alarme_pkg.sv - shared state encodings and sizing helper for the siren controller
package alarme_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] DESARMADO = 3'd0;
    localparam logic [STATE_W-1:0] ARMADO    = 3'd1;
    localparam logic [STATE_W-1:0] ESPERA    = 3'd2;
    localparam logic [STATE_W-1:0] DISPARO   = 3'd3;
    localparam logic [STATE_W-1:0] REARME    = 3'd4;

    // Timer only has to reach limit-1, so clog2 of the larger limit suffices.
    function automatic int timer_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/alarme_temporizador.sv
// rtl/alarme_temporizador.sv - up-counter with synchronous clear and terminal-count flag
module alarme_temporizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == last_i);

endmodule

// File: rtl/alarme_sirene.sv
// rtl/alarme_sirene.sv - arm/disarm, entry delay with beep, timed siren and event counter
module alarme_sirene
    import alarme_pkg::*;
#(
    parameter int ENTRY_DELAY = 8,
    parameter int SIREN_TIME  = 16,
    parameter int BEEP_PERIOD = 2,
    parameter int EVW         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               A,
    input  logic               ARM,
    input  logic               CODE_OK,
    output logic               SIREN,
    output logic               BEEP,
    output logic               ARMED,
    output logic [STATE_W-1:0] STATE,
    output logic [EVW-1:0]     EVENTS
);

    localparam int TW = timer_w(ENTRY_DELAY, SIREN_TIME);

    logic [STATE_W-1:0] state_q, state_d;
    logic               beep_q, beep_d;
    logic [EVW-1:0]     events_q, events_d;
    logic [TW-1:0]      timer;
    logic [TW-1:0]      timer_last;
    logic               timer_tc;
    logic               beep_toggle;

    // One timer serves both timed states; it is cleared on every state change.
    assign timer_last = (state_q == DISPARO) ? TW'(SIREN_TIME - 1) : TW'(ENTRY_DELAY - 1);

    alarme_temporizador #(.W(TW)) u_temporizador (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_d != state_q),
        .en_i    ((state_q == ESPERA) || (state_q == DISPARO)),
        .last_i  (timer_last),
        .count_o (timer),
        .tc_o    (timer_tc)
    );

    assign beep_toggle = (((int'(timer) + 1) % BEEP_PERIOD) == 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DESARMADO;
            beep_q   <= 1'b0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            beep_q   <= beep_d;
            events_q <= events_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DESARMADO: if (ARM) state_d = ARMADO;
            ARMADO: begin
                if (CODE_OK)  state_d = DESARMADO;
                else if (A)   state_d = ESPERA;
            end
            ESPERA: begin
                if (CODE_OK)       state_d = DESARMADO;
                else if (timer_tc) state_d = DISPARO;
            end
            DISPARO: begin
                if (CODE_OK)       state_d = DESARMADO;
                else if (timer_tc) state_d = REARME;
            end
            REARME: begin
                if (CODE_OK)  state_d = DESARMADO;
                else if (!A)  state_d = ARMADO;
            end
            default: state_d = DESARMADO;
        endcase
    end

    // BEEP is only ever high while in, or entering, the entry delay.
    always_comb begin
        beep_d   = 1'b0;
        events_d = events_q;
        if ((state_q == ARMADO) && !CODE_OK && A) begin
            beep_d = 1'b1;
        end else if ((state_q == ESPERA) && !CODE_OK) begin
            if (timer_tc) begin
                if (events_q != {EVW{1'b1}}) events_d = events_q + EVW'(1);
            end else begin
                beep_d = beep_q ^ beep_toggle;
            end
        end
    end

    always_comb begin
        SIREN  = (state_q == DISPARO);
        ARMED  = (state_q != DESARMADO);
        STATE  = state_q;
        BEEP   = beep_q;
        EVENTS = events_q;
    end

endmodule

// File: tb/tb_alarme_sirene.sv
// tb/tb_alarme_sirene.sv - directed bench with a timestamp-based reference model
module tb_alarme_sirene;

    localparam int ED  = 8;
    localparam int ST  = 16;
    localparam int BP  = 2;
    localparam int EVW = 4;
    localparam int EV_MAX = (1 << EVW) - 1;

    localparam int P_OFF = 0, P_ARMED = 1, P_WAIT = 2, P_SIREN = 3, P_HOLD = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           A = 1'b0;
    logic           ARM = 1'b0;
    logic           CODE_OK = 1'b0;
    logic           SIREN;
    logic           BEEP;
    logic           ARMED;
    logic [2:0]     STATE;
    logic [EVW-1:0] EVENTS;

    int checks = 0;
    int errors = 0;

    // Model: phase plus the edge number at which the current timed phase began.
    int ph = P_OFF;
    int t_mark = 0;
    int n = 0;
    int ev = 0;
    bit model_valid = 0;
    bit siren_seen = 0;

    alarme_sirene #(
        .ENTRY_DELAY (ED),
        .SIREN_TIME  (ST),
        .BEEP_PERIOD (BP),
        .EVW         (EVW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .ARM     (ARM),
        .CODE_OK (CODE_OK),
        .SIREN   (SIREN),
        .BEEP    (BEEP),
        .ARMED   (ARMED),
        .STATE   (STATE),
        .EVENTS  (EVENTS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic model_step();
        n++;
        if (rst) begin
            ph = P_OFF;
            ev = 0;
            model_valid = 1;
        end else begin
            case (ph)
                P_OFF:   if (ARM) ph = P_ARMED;
                P_ARMED: if (CODE_OK) ph = P_OFF;
                         else if (A) begin ph = P_WAIT; t_mark = n; end
                P_WAIT:  if (CODE_OK) ph = P_OFF;
                         else if (n - t_mark == ED) begin
                             ph = P_SIREN;
                             t_mark = n;
                             if (ev < EV_MAX) ev++;
                         end
                P_SIREN: if (CODE_OK) ph = P_OFF;
                         else if (n - t_mark == ST) ph = P_HOLD;
                P_HOLD:  if (CODE_OK) ph = P_OFF;
                         else if (!A) ph = P_ARMED;
                default: ph = P_OFF;
            endcase
        end
    endtask

    task automatic compare_all();
        logic exp_beep;
        if (!model_valid) return;
        exp_beep = (ph == P_WAIT) && ((((n - t_mark) / BP) % 2) == 0);
        chk("m_state", 32'(STATE), 32'(ph));
        chk("m_siren", 32'(SIREN), 32'(ph == P_SIREN));
        chk("m_armed", 32'(ARMED), 32'(ph != P_OFF));
        chk("m_beep", 32'(BEEP), 32'(exp_beep));
        chk("m_events", 32'(EVENTS), 32'(ev));
        if (SIREN === 1'b1) siren_seen = 1;
    endtask

    task automatic tick(input int cnt = 1);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; A = 1'b0; ARM = 1'b0; CODE_OK = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic arm_it();
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
    endtask

    logic [7:0] beep_seen;
    logic [7:0] beep_ref;

    initial begin
        // Reset with A and ARM active
        rst = 1'b1; A = 1'b1; ARM = 1'b1;
        tick(2);
        chk("rst_state", 32'(STATE), 0);
        chk("rst_siren", 32'(SIREN), 0);
        chk("rst_beep", 32'(BEEP), 0);
        chk("rst_armed", 32'(ARMED), 0);
        chk("rst_events", 32'(EVENTS), 0);
        rst = 1'b0;
        tick();
        chk("arm_after_rst", 32'(ARMED), 1);
        ARM = 1'b0; A = 1'b0;
        tick();

        // Full alarm from a one-cycle pulse on A
        A = 1'b1;
        tick();
        A = 1'b0;
        beep_seen[7] = BEEP;
        chk("full_state_espera", 32'(STATE), 2);
        for (int j = 6; j >= 0; j--) begin
            tick();
            beep_seen[j] = BEEP;
        end
        beep_ref = 8'b1100_1100;
        chk("full_beep_pattern", 32'(beep_seen), 32'(beep_ref));
        chk("full_siren_pre", 32'(SIREN), 0);
        tick();
        chk("full_siren_k8", 32'(SIREN), 1);
        chk("full_events", 32'(EVENTS), 1);
        tick(15);
        chk("full_siren_k23", 32'(SIREN), 1);
        tick();
        chk("full_siren_k24", 32'(SIREN), 0);
        chk("full_state_rearme", 32'(STATE), 4);
        tick();
        chk("full_state_armado", 32'(STATE), 1);

        // Disarm during entry delay
        do_reset();
        arm_it();
        siren_seen = 0;
        A = 1'b1;
        tick();
        A = 1'b0;
        tick(4);
        CODE_OK = 1'b1;
        tick();
        CODE_OK = 1'b0;
        chk("dly_state", 32'(STATE), 0);
        chk("dly_beep", 32'(BEEP), 0);
        chk("dly_events", 32'(EVENTS), 0);
        tick(ED + 2);
        chk("dly_no_siren", 32'(siren_seen), 0);

        // Disarm at the third siren cycle
        arm_it();
        A = 1'b1;
        tick();
        A = 1'b0;
        tick(ED);
        chk("mid_siren_on", 32'(SIREN), 1);
        tick(2);
        CODE_OK = 1'b1;
        tick();
        CODE_OK = 1'b0;
        chk("mid_siren_off", 32'(SIREN), 0);
        chk("mid_state", 32'(STATE), 0);
        chk("mid_events", 32'(EVENTS), 1);

        // A held through the siren blocks re-arming
        do_reset();
        arm_it();
        A = 1'b1;
        tick(1 + ED + ST);
        chk("held_rearme", 32'(STATE), 4);
        tick(5);
        chk("held_still_rearme", 32'(STATE), 4);
        A = 1'b0;
        tick();
        chk("held_drop_armado", 32'(STATE), 1);
        A = 1'b1;
        tick();
        chk("held_new_espera", 32'(STATE), 2);
        A = 1'b0;
        tick(ED);
        chk("held_events2", 32'(EVENTS), 2);
        CODE_OK = 1'b1;
        tick();
        CODE_OK = 1'b0;

        // Event counter saturation
        do_reset();
        for (int t = 0; t < 17; t++) begin
            arm_it();
            A = 1'b1;
            tick();
            A = 1'b0;
            tick(ED);
            CODE_OK = 1'b1;
            tick();
            CODE_OK = 1'b0;
            if (t == 14) chk("sat_events15", 32'(EVENTS), 15);
        end
        chk("sat_events_hold", 32'(EVENTS), 15);

        // Priority: CODE_OK beats A in ARMADO; ARM wins in DESARMADO
        arm_it();
        A = 1'b1; CODE_OK = 1'b1;
        tick();
        chk("prio_code_over_a", 32'(STATE), 0);
        A = 1'b0; ARM = 1'b1;
        tick();
        ARM = 1'b0; CODE_OK = 1'b0;
        chk("prio_arm_with_code", 32'(STATE), 1);

        // Reset during the siren
        A = 1'b1;
        tick(1 + ED + 3);
        chk("rst_mid_siren_on", 32'(SIREN), 1);
        rst = 1'b1;
        tick();
        chk("rstd_siren", 32'(SIREN), 0);
        chk("rstd_state", 32'(STATE), 0);
        chk("rstd_armed", 32'(ARMED), 0);
        chk("rstd_beep", 32'(BEEP), 0);
        chk("rstd_events", 32'(EVENTS), 0);
        rst = 1'b0; A = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
